// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and divider width helper.
// Segment codes are active-low in bit order g..a (bit 0 = segment a).
package seg_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Drive level that lights a segment or enables a digit anode.
    localparam logic SEG_ACTIVE = 1'b0;

    // Counter width for a divider of n states; at least one bit so a
    // divide-by-1 still has a legal (constant-zero) register.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational BCD digit to active-low seven-segment code.
// Ports: bcd_i - 4-bit BCD digit; seg_o - segments g..a, active-low.
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_seg_counter.sv
// seven_seg_counter: prescaled multi-digit BCD up/down counter with a
// time-multiplexed seven-segment display driver.
// Ports: clock_in - clock; rst - async active-high reset; en - count enable;
//        up - direction (1 = up); clr - sync clear of count and prescaler;
//        count - BCD value, digit 0 in [3:0]; carry - wrap pulse;
//        seg - active-low segments g..a; an - active-low one-hot anodes.
module seven_seg_counter
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clock_in,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int TW = cnt_w(TICK_DIV);
    localparam int SW = cnt_w(SCAN_DIV);
    localparam int IW = cnt_w(DIGITS);
    localparam int CW = 4 * DIGITS;

    logic [TW-1:0]     pre_q, pre_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d, bcd_next;
    logic              carry_q, carry_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [3:0]        dsel, dig, nd;
    logic              tick, wrap, scan_tc, rip;

    assign tick    = en && (pre_q == TW'(TICK_DIV - 1));
    assign pre_d   = (clr || tick) ? '0 : en ? pre_q + TW'(1) : pre_q;
    assign scan_tc = scan_q == SW'(SCAN_DIV - 1);
    assign scan_d  = scan_tc ? '0 : scan_q + SW'(1);
    assign idx_d   = !scan_tc ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

    // Ripple BCD step: a digit moves only while every lower digit wraps;
    // a ripple surviving past the top digit is the whole-counter wrap.
    always_comb begin
        rip      = 1'b1;
        bcd_next = count_q;
        dig      = '0;
        nd       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            nd  = up ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1)
                     : ((dig == 4'd0) ? 4'd9 : dig - 4'd1);
            bcd_next[4*i +: 4] = rip ? nd : dig;
            rip = rip & (up ? (dig == 4'd9) : (dig == 4'd0));
        end
        wrap = rip;
    end

    assign count_d = clr ? '0 : tick ? bcd_next : count_q;
    assign carry_d = tick && !clr && wrap;

    // Digit mux and anode select from the pre-edge index.
    always_comb begin
        dsel = '0;
        an_d = {DIGITS{~SEG_ACTIVE}};
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dsel    = count_q[4*i +: 4];
                an_d[i] = SEG_ACTIVE;
            end
        end
    end

    bcd_seg_decode u_dec (
        .bcd_i (dsel),
        .seg_o (seg_d)
    );

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            pre_q   <= pre_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            carry_q <= carry_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign seg   = seg_q;
    assign an    = an_q;
endmodule

// File: tb/tb_seven_seg_counter.sv
// tb_seven_seg_counter: self-checking bench for seven_seg_counter.
module tb_seven_seg_counter;
    localparam int DA = 2, TA = 1, SA = 3;
    localparam int DB = 4, TDB = 4, SB = 2;

    logic clk = 0, rst = 0;
    logic en_a = 0, up_a = 1, clr_a = 0;
    logic en_b = 0, up_b = 1, clr_b = 0;
    logic [7:0]  count_a;
    logic        carry_a;
    logic [6:0]  seg_a;
    logic [1:0]  an_a;
    logic [15:0] count_b;
    logic        carry_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    seven_seg_counter #(.DIGITS(DA), .TICK_DIV(TA), .SCAN_DIV(SA)) dut_a (
        .clock_in(clk), .rst(rst), .en(en_a), .up(up_a), .clr(clr_a),
        .count(count_a), .carry(carry_a), .seg(seg_a), .an(an_a));

    seven_seg_counter #(.DIGITS(DB), .TICK_DIV(TDB), .SCAN_DIV(SB)) dut_b (
        .clock_in(clk), .rst(rst), .en(en_b), .up(up_b), .clr(clr_b),
        .count(count_b), .carry(carry_b), .seg(seg_b), .an(an_b));

    always #5 clk = ~clk;

    typedef struct {
        int          val;
        int          pre;
        bit          carry;
        int          scan;
        int          idx;
        logic [6:0]  seg;
        logic [31:0] an;
    } ms_t;

    typedef struct {
        logic       en;
        logic       up;
        logic       clr;
        logic [7:0] cnt;
        logic       cy;
    } vec_t;

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int pw10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / pw10(i)) % 10);
        return r;
    endfunction

    function automatic ms_t m_reset(input int d);
        ms_t s;
        s.val = 0; s.pre = 0; s.carry = 0; s.scan = 0; s.idx = 0;
        s.seg = 7'h7F;
        s.an  = (32'd1 << d) - 1;
        return s;
    endfunction

    // Reference: integer count modulo 10^d, prescaler and scan as plain ints.
    function automatic ms_t m_step(input ms_t s, input int d, input int t, input int sd,
                                   input logic en, input logic up, input logic clr);
        ms_t n = s;
        int  top = pw10(d);
        bit  tk = en && (s.pre == t - 1);
        n.carry = 0;
        if (clr) begin
            n.val = 0;
            n.pre = 0;
        end else if (en) begin
            n.pre = tk ? 0 : s.pre + 1;
            if (tk) begin
                n.val   = up ? (s.val + 1) % top : (s.val + top - 1) % top;
                n.carry = up ? (s.val == top - 1) : (s.val == 0);
            end
        end
        n.seg  = segtab[(s.val / pw10(s.idx)) % 10];
        n.an   = ~(32'd1 << s.idx) & ((32'd1 << d) - 1);
        n.scan = (s.scan == sd - 1) ? 0 : s.scan + 1;
        if (s.scan == sd - 1) n.idx = (s.idx + 1) % d;
        return n;
    endfunction

    ms_t ma, mb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= m_reset(DA);
            mb <= m_reset(DB);
        end else begin
            ma <= m_step(ma, DA, TA, SA, en_a, up_a, clr_a);
            mb <= m_step(mb, DB, TDB, SB, en_b, up_b, clr_b);
        end
    end

    int nchk = 0, nerr = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    bit mon = 0;
    always @(negedge clk) begin
        if (mon) begin
            chk("a.count", 32'(count_a), to_bcd(ma.val, DA));
            chk("a.carry", 32'(carry_a), 32'(ma.carry));
            chk("a.seg",   32'(seg_a),   32'(ma.seg));
            chk("a.an",    32'(an_a),    ma.an);
            chk("b.count", 32'(count_b), to_bcd(mb.val, DB));
            chk("b.carry", 32'(carry_b), 32'(mb.carry));
            chk("b.seg",   32'(seg_b),   32'(mb.seg));
            chk("b.an",    32'(an_b),    mb.an);
        end
    end

    function automatic logic [6:0] seg_for_an(input logic [3:0] a);
        return a == 4'hE ? 7'h19 : a == 4'hD ? 7'h30 : a == 4'hB ? 7'h24 : a == 4'h7 ? 7'h79 : 7'h7F;
    endfunction

    vec_t tv [12];
    int   ncy, run, seen;
    logic [3:0] prev;
    bit   started;

    initial begin
        tv[0]  = '{1, 0, 0, 8'h99, 1};
        tv[1]  = '{1, 0, 0, 8'h98, 0};
        tv[2]  = '{1, 1, 0, 8'h99, 0};
        tv[3]  = '{1, 1, 0, 8'h00, 1};
        tv[4]  = '{0, 1, 0, 8'h00, 0};
        tv[5]  = '{1, 1, 0, 8'h01, 0};
        tv[6]  = '{1, 0, 0, 8'h00, 0};
        tv[7]  = '{1, 1, 1, 8'h00, 0};
        tv[8]  = '{1, 0, 0, 8'h99, 1};
        tv[9]  = '{0, 0, 1, 8'h00, 0};
        tv[10] = '{1, 0, 0, 8'h99, 1};
        tv[11] = '{0, 1, 0, 8'h99, 0};

        #1 rst = 1;
        #1 mon = 1;
        repeat (3) @(negedge clk);
        chk("rst.an",    32'(an_b),    32'hF);
        chk("rst.seg",   32'(seg_b),   32'h7F);
        chk("rst.count", 32'(count_b), 32'h0);
        chk("rst.carry", 32'(carry_b), 32'h0);
        rst = 0;
        @(negedge clk);
        chk("rel.an",  32'(an_b),  32'hE);
        chk("rel.seg", 32'(seg_b), 32'h40);

        foreach (tv[i]) begin
            en_a = tv[i].en; up_a = tv[i].up; clr_a = tv[i].clr;
            @(negedge clk);
            chk($sformatf("tv%0d.count", i), 32'(count_a), 32'(tv[i].cnt));
            chk($sformatf("tv%0d.carry", i), 32'(carry_a), 32'(tv[i].cy));
        end
        en_a = 0; clr_a = 1;
        @(negedge clk);
        clr_a = 0; en_a = 1; up_a = 1; ncy = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            chk("up.count", 32'(count_a), to_bcd(i % 100, 2));
            if (carry_a) begin
                ncy++;
                chk("up.carry_at", 32'(count_a), 32'h0);
            end
        end
        chk("up.ncarry", 32'(ncy), 32'd1);
        repeat (10) @(negedge clk);
        chk("borrow.pre", 32'(count_a), 32'h10);
        up_a = 0;
        @(negedge clk);
        chk("borrow.post", 32'(count_a), 32'h09);
        en_a = 0;

        clr_b = 1;
        @(negedge clk);
        clr_b = 0; en_b = 1; up_b = 1;
        repeat (2) @(negedge clk);
        chk("freeze.pre", 32'(count_b), 32'h0);
        en_b = 0;
        repeat (6) begin
            @(negedge clk);
            chk("freeze.hold", 32'(count_b), 32'h0);
        end
        en_b = 1;
        @(negedge clk);
        chk("freeze.r1", 32'(count_b), 32'h0);
        @(negedge clk);
        chk("freeze.r2", 32'(count_b), 32'h1);

        clr_b = 1;
        @(negedge clk);
        clr_b = 0;
        repeat (37 * 4) @(negedge clk);
        chk("clr.at37", 32'(count_b), 32'h37);
        repeat (3) @(negedge clk);
        clr_b = 1;
        @(negedge clk);
        clr_b = 0;
        chk("clr.count", 32'(count_b), 32'h0);
        chk("clr.carry", 32'(carry_b), 32'h0);
        repeat (3) @(negedge clk);
        chk("clr.wait", 32'(count_b), 32'h0);
        @(negedge clk);
        chk("clr.next", 32'(count_b), 32'h1);

        clr_b = 1;
        @(negedge clk);
        clr_b = 0;
        repeat (1234 * 4) @(negedge clk);
        en_b = 0;
        chk("scan.count", 32'(count_b), 32'h1234);
        prev = an_b; run = 0; seen = 0; started = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("scan.seg", 32'(seg_b), 32'(seg_for_an(an_b)));
            if (an_b != prev) begin
                if (started) chk("scan.run", 32'(run), 32'd2);
                chk("scan.order", 32'(an_b), 32'({prev[2:0], prev[3]}));
                started = 1; run = 1; prev = an_b; seen++;
            end else run++;
        end
        chk("scan.slots", 32'(seen >= 7), 32'd1);

        for (int i = 0; i < 400; i++) begin
            en_a = 1'($urandom_range(0, 1)); up_a = 1'($urandom_range(0, 1));
            clr_a = ($urandom_range(0, 15) == 0);
            en_b = ($urandom_range(0, 3) != 0); up_b = 1'($urandom_range(0, 1));
            clr_b = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end

        clr_a = 0; clr_b = 0; en_a = 1; en_b = 1; up_b = 1;
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst.count_b", 32'(count_b), 32'h0);
        chk("arst.an_b",    32'(an_b),    32'hF);
        chk("arst.seg_b",   32'(seg_b),   32'h7F);
        chk("arst.count_a", 32'(count_a), 32'h0);
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("arst.hold", 32'(count_b), 32'h0);
        @(negedge clk);
        chk("arst.first", 32'(count_b), 32'h1);
        repeat (5) @(negedge clk);
        mon = 0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/seven_seg_counter.md
Name: seven_seg_counter

Overview:
Parametrised multi-digit BCD up/down counter with a time-multiplexed seven-segment display driver. It is the successor to the single-digit 3-bit counter/decoder. It adds a configurable digit count, a tick prescaler, direction control, synchronous clear, a carry/borrow output and anode scanning. It sits between the board clock and the seven-segment display pins.

Parameters:
- DIGITS, 4, number of BCD digits displayed and counted; legal range 1..8.
- TICK_DIV, 50000000, clock cycles per count tick; 1 means tick every cycle; must be >= 1.
- SCAN_DIV, 50000, clock cycles per display digit slot; must be >= 1.

Ports:
- clock_in  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; the prescaler and count advance only while en=1.
- up  in  1  direction; 1 = increment, 0 = decrement; sampled at the tick.
- clr  in  1  synchronous clear of count and prescaler.
- count  out  4*DIGITS  registered BCD value; digit 0 (least significant) in bits [3:0].
- carry  out  1  one-cycle pulse on wrap (99..9->0 going up, 0->99..9 going down).
- seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g; registered.
- an  out  DIGITS  digit anodes, active-low, one-hot-low; registered.

Behaviour:
- Reset (async, rst=1): count=0, carry=0, prescaler=0, scan counter=0, digit index=0, an=all ones (all digits off), seg=7'h7F (blank).
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and holds while en=0.
  - tick=1 in the cycle where prescaler==TICK_DIV-1 and en=1; the prescaler then wraps to 0.
- Count update on tick:
  - Ripple BCD increment or decrement across all DIGITS; each digit stays within 0..9.
  - The new value is visible on count at the next edge.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - carry=1 for exactly the cycle after that edge, i.e. concurrent with the wrapped count value. Otherwise carry=0.
- clr=1:
  - On the next edge, count=0 and prescaler=0; no carry.
  - clr has priority over a simultaneous tick.
  - clr does not affect the scan logic.
- Changing up between ticks has no effect until the next tick.
- Scan counter:
  - Free-running 0..SCAN_DIV-1, independent of en and clr.
  - At terminal count the digit index advances, wrapping DIGITS-1 -> 0.
  - With DIGITS=1 the index stays 0.
- Display outputs, registered every cycle:
  - an <= ~(1<<index).
  - seg <= decode(count digit[index]), using the pre-edge count and index. This gives one cycle of latency from a count or index change to seg/an.
- Decode, active-low bit order g..a:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10..15 cannot occur; decode them to blank 7'h7F.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values. Counting resumes from 0 on the first edge after rst deasserts.

Decomposition:
- Shared package seg_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - the active-low polarity constant;
  - a clog2-based width helper for the dividers.
- One sub-module: bcd_seg_decode, a combinational 4-bit BCD to active-low 7-segment decoder, instantiated once after the digit mux.

Test Plan:
- Assert rst for 3 cycles, then release -> during reset an=4'hF, seg=7'h7F, count=0, carry=0; one cycle after release an=4'hE, seg=7'h40.
- DIGITS=2, TICK_DIV=1, up=1, en=1 for 100 cycles -> count steps 00,01..99,00; carry pulses exactly once, in the cycle count reads 00 after 99.
- DIGITS=2, TICK_DIV=1, up=0 from 00 -> next value 99 with a carry pulse; then 98; count 10 -> 09 (borrow across digits).
- TICK_DIV=4, en toggled low for 6 cycles mid-period -> count increments only after 4 enabled cycles; value and prescaler frozen while en=0.
- Count=37, assert clr in the same cycle as a tick -> count=00, no carry; the next increment occurs TICK_DIV enabled cycles later.
- DIGITS=4, SCAN_DIV=2, count=1234 -> an cycles E,D,B,7 every 2 cycles; seg follows one cycle later as 7'h19 (digit 0 = 4), 7'h30 (3), 7'h24 (2), 7'h79 (1); the sequence repeats.
